// File: rtl/hilo_file_pkg.sv
// ============================================================================
// Module      : hilo_file_pkg
// Description : Shared types and constants for the HI/LO write pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_file_pkg;

    localparam int HILO_WIDTH = 32;

    // One in-flight HI/LO write (M or W slot).
    typedef struct packed {
        logic                  valid;
        logic                  we_hi;
        logic                  we_lo;
        logic [HILO_WIDTH-1:0] hi;
        logic [HILO_WIDTH-1:0] lo;
    } hilo_slot_t;

    localparam hilo_slot_t HILO_BUBBLE = '0;

    typedef enum logic [1:0] {
        SRC_ARCH = 2'd0,
        SRC_W    = 2'd1,
        SRC_M    = 2'd2
    } fwd_src_e;

endpackage : hilo_file_pkg

`default_nettype wire

// File: rtl/hilo_file_fwd_mux.sv
// ============================================================================
// Module      : hilo_fwd_mux
// Description : Youngest-first forward select for one of HI or LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_fwd_mux
    import hilo_file_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             m_sel_i,
    input  logic             w_sel_i,
    input  logic [WIDTH-1:0] m_val_i,
    input  logic [WIDTH-1:0] w_val_i,
    input  logic [WIDTH-1:0] arch_val_i,
    output logic [WIDTH-1:0] fwd_o
);

    fwd_src_e w_src;

    always_comb begin
        w_src = SRC_ARCH;
        if (m_sel_i) begin
            w_src = SRC_M;
        end else if (w_sel_i) begin
            w_src = SRC_W;
        end
    end

    always_comb begin
        fwd_o = arch_val_i;
        case (w_src)
            SRC_M:   fwd_o = m_val_i;
            SRC_W:   fwd_o = w_val_i;
            default: fwd_o = arch_val_i;
        endcase
    end

endmodule : hilo_fwd_mux

`default_nettype wire

// File: rtl/hilo_file.sv
// ============================================================================
// Module      : hilo_file
// Description : Architectural HI/LO pair with M/W write pipeline and forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_file
    import hilo_file_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             e_valid,
    input  logic             e_we_hi,
    input  logic             e_we_lo,
    input  logic [WIDTH-1:0] e_hi,
    input  logic [WIDTH-1:0] e_lo,
    output logic [WIDTH-1:0] fwd_hi,
    output logic [WIDTH-1:0] fwd_lo,
    output logic [WIDTH-1:0] arch_hi,
    output logic [WIDTH-1:0] arch_lo,
    output logic             pending
);

    hilo_slot_t       m_q, m_d;
    hilo_slot_t       w_q, w_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             w_advance;

    // Flush still lets W retire; only stall without flush freezes everything.
    assign w_advance = flush | ~stall;

    always_comb begin
        m_d  = m_q;
        w_d  = w_q;
        hi_d = hi_q;
        lo_d = lo_q;

        if (w_advance) begin
            if (w_q.valid && w_q.we_hi) hi_d = WIDTH'(w_q.hi);
            if (w_q.valid && w_q.we_lo) lo_d = WIDTH'(w_q.lo);
        end

        if (flush) begin
            m_d = HILO_BUBBLE;
            w_d = HILO_BUBBLE;
        end else if (!stall) begin
            w_d       = m_q;
            m_d.valid = e_valid;
            m_d.we_hi = e_we_hi;
            m_d.we_lo = e_we_lo;
            m_d.hi    = HILO_WIDTH'(e_hi);
            m_d.lo    = HILO_WIDTH'(e_lo);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q  <= HILO_BUBBLE;
            w_q  <= HILO_BUBBLE;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            m_q  <= m_d;
            w_q  <= w_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    hilo_fwd_mux #(.WIDTH(WIDTH)) u_fwd_hi (
        .m_sel_i    (m_q.valid & m_q.we_hi),
        .w_sel_i    (w_q.valid & w_q.we_hi),
        .m_val_i    (WIDTH'(m_q.hi)),
        .w_val_i    (WIDTH'(w_q.hi)),
        .arch_val_i (hi_q),
        .fwd_o      (fwd_hi)
    );

    hilo_fwd_mux #(.WIDTH(WIDTH)) u_fwd_lo (
        .m_sel_i    (m_q.valid & m_q.we_lo),
        .w_sel_i    (w_q.valid & w_q.we_lo),
        .m_val_i    (WIDTH'(m_q.lo)),
        .w_val_i    (WIDTH'(w_q.lo)),
        .arch_val_i (lo_q),
        .fwd_o      (fwd_lo)
    );

    assign arch_hi = hi_q;
    assign arch_lo = lo_q;
    assign pending = (m_q.valid & (m_q.we_hi | m_q.we_lo))
                   | (w_q.valid & (w_q.we_hi | w_q.we_lo));

endmodule : hilo_file

`default_nettype wire

// File: tb/tb_hilo_file.sv
// ============================================================================
// Module      : tb_hilo_file
// Description : Directed self-checking bench for hilo_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_file;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             flush;
    logic             e_valid;
    logic             e_we_hi;
    logic             e_we_lo;
    logic [WIDTH-1:0] e_hi;
    logic [WIDTH-1:0] e_lo;
    logic [WIDTH-1:0] fwd_hi;
    logic [WIDTH-1:0] fwd_lo;
    logic [WIDTH-1:0] arch_hi;
    logic [WIDTH-1:0] arch_lo;
    logic             pending;

    int n_vec  = 0;
    int n_miss = 0;

    hilo_file #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .e_valid (e_valid),
        .e_we_hi (e_we_hi),
        .e_we_lo (e_we_lo),
        .e_hi    (e_hi),
        .e_lo    (e_lo),
        .fwd_hi  (fwd_hi),
        .fwd_lo  (fwd_lo),
        .arch_hi (arch_hi),
        .arch_lo (arch_lo),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_e(input logic v, input logic wh, input logic wl,
                         input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        e_valid = v;
        e_we_hi = wh;
        e_we_lo = wl;
        e_hi    = h;
        e_lo    = l;
    endtask

    task automatic idle();
        set_e(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] fh,
                           input logic [WIDTH-1:0] fl, input logic [WIDTH-1:0] ah,
                           input logic [WIDTH-1:0] al, input logic p);
        chk({tag, ".fwd_hi"},  fwd_hi,  fh);
        chk({tag, ".fwd_lo"},  fwd_lo,  fl);
        chk({tag, ".arch_hi"}, arch_hi, ah);
        chk({tag, ".arch_lo"}, arch_lo, al);
        chk({tag, ".pending"}, WIDTH'(pending), WIDTH'(p));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        #2;
        chk_all("reset", 0, 0, 0, 0, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("idle", 0, 0, 0, 0, 1'b0);
        end

        // MULT: E inputs must not leak combinationally to any output
        set_e(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
        #1;
        chk_all("mult.e_only", 0, 0, 0, 0, 1'b0);
        step();
        idle();
        chk_all("mult.e1", 32'hFFFF_FFFF, 32'h2, 0, 0, 1'b1);
        step();
        chk_all("mult.e2", 32'hFFFF_FFFF, 32'h2, 0, 0, 1'b1);
        step();
        chk_all("mult.e3", 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'h2, 1'b0);

        // MTHI then MTLO: HI forwarded from W, LO from M
        set_e(1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_0000);
        step();
        set_e(1'b1, 1'b0, 1'b1, 32'hDEAD_1111, 32'h2222_2222);
        step();
        idle();
        chk_all("mthilo.split", 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 32'h2, 1'b1);
        step();
        chk_all("mthilo.hi_commit", 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2, 1'b1);
        step();
        chk_all("mthilo.lo_commit", 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 1'b0);

        // Back-to-back HI writes: M wins over W
        set_e(1'b1, 1'b1, 1'b0, 32'hA, 32'h0);
        step();
        set_e(1'b1, 1'b1, 1'b0, 32'hB, 32'h0);
        step();
        idle();
        chk("b2b.fwd_hi", fwd_hi, 32'hB);
        step();
        chk("b2b.arch_hi_a", arch_hi, 32'hA);
        chk("b2b.fwd_hi_w", fwd_hi, 32'hB);
        step();
        chk_all("b2b.done", 32'hB, 32'h2222_2222, 32'hB, 32'h2222_2222, 1'b0);

        // DIV in M, then 3 stalled cycles with a live E write to ignore
        set_e(1'b1, 1'b1, 1'b1, 32'h3, 32'h7);
        step();
        set_e(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall.hold", 32'h3, 32'h7, 32'hB, 32'h2222_2222, 1'b1);
        end
        stall = 1'b0;
        idle();
        step();
        chk_all("stall.rel1", 32'h3, 32'h7, 32'hB, 32'h2222_2222, 1'b1);
        step();
        chk_all("stall.rel2", 32'h3, 32'h7, 32'h3, 32'h7, 1'b0);

        // Flush with stall: W retires 0x5, M (0x9) and E (0xC) dropped
        set_e(1'b1, 1'b1, 1'b0, 32'h5, 32'h0);
        step();
        set_e(1'b1, 1'b1, 1'b0, 32'h9, 32'h0);
        step();
        chk("flush.pre_fwd_hi", fwd_hi, 32'h9);
        set_e(1'b1, 1'b1, 1'b0, 32'hC, 32'h0);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        chk_all("flush.post", 32'h5, 32'h7, 32'h5, 32'h7, 1'b0);
        step();
        step();
        chk_all("flush.later", 32'h5, 32'h7, 32'h5, 32'h7, 1'b0);

        // Async reset mid-flight: no partial commit afterwards
        set_e(1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321);
        step();
        idle();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_all("areset.now", 0, 0, 0, 0, 1'b0);
        step();
        reset = 1'b0;
        step();
        step();
        chk_all("areset.after", 0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_hilo_file

`default_nettype wire

// File: doc/hilo_file.md
Name: hilo_file

Overview:
- Architectural HI/LO register pair for the MIPS core, plus the in-flight HI/LO write pipeline between execute and writeback.
- Captures the execute-stage HI/LO results (MULT/MULTU/DIV/DIVU/MTHI/MTLO) and carries them through the M and W slots.
- Commits each write at the end of W.
- Forwards the youngest pending value back to the execute-stage multiply/divide unit, which uses it as its pass-through HI/LO.

Parameters:
- WIDTH, 32, data width of HI and LO.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline freeze: M slot, W slot and architectural registers hold.
- flush  in  1  exception/flush at M: kills the E capture and the M slot.
- e_valid  in  1  execute-stage instruction is real (not a bubble).
- e_we_hi  in  1  execute instruction writes HI.
- e_we_lo  in  1  execute instruction writes LO.
- e_hi  in  WIDTH  HI value produced in execute.
- e_lo  in  WIDTH  LO value produced in execute.
- fwd_hi  out  WIDTH  HI value visible to the execute stage.
- fwd_lo  out  WIDTH  LO value visible to the execute stage.
- arch_hi  out  WIDTH  committed HI.
- arch_lo  out  WIDTH  committed LO.
- pending  out  1  any valid HI/LO write in M or W.

Behaviour:
- State:
  - Slot M: valid, we_hi, we_lo, hi, lo.
  - Slot W: same fields as M.
  - Architectural registers hi_r and lo_r.
- Reset (async, active-high): all slot fields, hi_r and lo_r go to 0. Therefore fwd_hi, fwd_lo, arch_hi and arch_lo are 0, and pending is 0. Reset asserted mid-operation discards both slots immediately; no partial commit.
- Normal edge (stall=0, flush=0):
  - W commits: if W.valid & W.we_hi then hi_r <= W.hi; if W.valid & W.we_lo then lo_r <= W.lo.
  - M shifts into W.
  - M <= {e_valid, e_we_hi, e_we_lo, e_hi, e_lo}.
  - An entry with both we bits 0 is stored as valid but commits nothing.
- stall=1, flush=0: M, W, hi_r and lo_r all hold; the E inputs are ignored.
- flush=1, regardless of stall (flush wins):
  - W commits and W <= bubble.
  - M <= bubble; the E inputs are discarded.
  - The M contents are dropped, not shifted into W.
- Write latency: an E write becomes architectural 2 edges after capture (E->M, M->W, commit on the W edge). It is visible on arch_* from the 3rd edge onward.
- Forwarding (combinational), per register independently:
  - fwd_hi = M.hi if M.valid & M.we_hi.
  - Else W.hi if W.valid & W.we_hi.
  - Else hi_r.
  - fwd_lo is the same using the we_lo bits and LO fields.
  - Priority is youngest first. Example: M writes only LO while W writes HI, so fwd_hi comes from W and fwd_lo from M.
- Same-cycle E write and read: the E write is not forwarded to itself; fwd_* reflects only M, W and architectural state.
- pending = (M.valid & (M.we_hi | M.we_lo)) | (W.valid & (W.we_hi | W.we_lo)).
- arch_hi = hi_r; arch_lo = lo_r. They are updated only by W commits.
- No combinational path from e_* to any output.

Decomposition:
- Shared core package:
  - typedef hilo_slot_t = struct {valid, we_hi, we_lo, hi[WIDTH], lo[WIDTH]}.
  - Constant HILO_BUBBLE (all zero).
- Sub-module hilo_fwd_mux: purely combinational selection of one register's forward value from (M, W, arch). Instantiated twice, once for HI and once for LO.

Test Plan:
- Reset with stall=0, then no writes for 5 cycles -> fwd_hi/fwd_lo/arch_hi/arch_lo = 0 and pending = 0 throughout.
- MULT capture with e_hi=0xFFFFFFFF, e_lo=0x00000002, both we bits set -> after edge 1, fwd = {0xFFFFFFFF, 0x00000002} and arch = 0. After edge 3, arch = the same values and pending = 0.
- MTHI 0x11111111, then next cycle MTLO 0x22222222 -> after the second edge, fwd_hi=0x11111111 (from W) and fwd_lo=0x22222222 (from M). Two edges later, arch = {0x11111111, 0x22222222}.
- Back-to-back writes to HI, 0xA then 0xB -> fwd_hi=0xB (M over W). After both commit, arch_hi=0xB.
- DIV result {hi=0x3, lo=0x7} in M, then assert stall for 3 cycles -> all outputs frozen at their pre-stall values. Release -> commit proceeds with the normal 2-edge latency.
- W holds HI=0x5 and M holds HI=0x9; assert flush together with stall and e_hi=0xC -> arch_hi=0x5, fwd_hi=0x5, pending=0. The 0x9 and 0xC writes never appear.
